// File: rtl/count_event_detector_if.sv
// Event-detector bus: counter samples and compare load in, queued event records out.
// Optional evt_ts field exists only when COUNT_EVT_TIMESTAMP_EN is defined.
interface count_event_detector_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]        count;
    logic                    count_vld;
    logic [WIDTH-1:0]        cmp_val;
    logic                    cmp_load;
    logic                    evt_valid;
    logic                    evt_ready;
    logic [1:0]              evt_wrap;
    logic                    evt_match;
    logic [WIDTH-1:0]        evt_count;
    logic [$clog2(DEPTH):0]  fifo_level;
    logic                    ovf;
    logic                    ovf_clr;
`ifdef COUNT_EVT_TIMESTAMP_EN
    logic [15:0]             evt_ts;
`endif

    modport master (
        output count, count_vld, cmp_val, cmp_load, evt_ready, ovf_clr,
        input  evt_valid, evt_wrap, evt_match, evt_count, fifo_level, ovf
`ifdef COUNT_EVT_TIMESTAMP_EN
        , input evt_ts
`endif
    );

    modport slave (
        input  count, count_vld, cmp_val, cmp_load, evt_ready, ovf_clr,
        output evt_valid, evt_wrap, evt_match, evt_count, fifo_level, ovf
`ifdef COUNT_EVT_TIMESTAMP_EN
        , output evt_ts
`endif
    );
endinterface

// File: rtl/count_event_detector.sv
// Wrap/compare-match detector on counter samples; records land at the FIFO head the edge after sampling,
// popped on evt_valid&&evt_ready; full FIFO drops new records and sets sticky ovf. COUNT_EVT_TIMESTAMP_EN adds evt_ts.
module count_event_detector #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    count_event_detector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        S_PRIME = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_cmp;
    logic [LW-1:0]    r_wr_cnt;
    logic [LW-1:0]    r_rd_cnt;
    logic             r_ovf;

    logic [1:0]       r_mem_wrap  [DEPTH];
    logic             r_mem_match [DEPTH];
    logic [WIDTH-1:0] r_mem_count [DEPTH];

    logic             w_sample;
    logic             w_up;
    logic             w_down;
    logic             w_match;
    logic [1:0]       w_wrap;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_nonempty;
    logic             w_wr_en;
    logic             w_drop;
    logic [LW-1:0]    w_level;
    logic [AW-1:0]    w_wr_ptr;
    logic [AW-1:0]    w_rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_PRIME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        case (r_state)
            S_PRIME: begin
                if (bus.count_vld) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_sample = bus.count_vld;
            end
            default: begin
                w_state_nxt = S_PRIME;
            end
        endcase
    end

    // With WIDTH=1 these reduce to 1->0 up-wrap and 0->1 down-wrap.
    assign w_up    = (r_prev == {WIDTH{1'b1}}) && (bus.count == {WIDTH{1'b0}});
    assign w_down  = (r_prev == {WIDTH{1'b0}}) && (bus.count == {WIDTH{1'b1}});
    assign w_match = (bus.count == r_cmp) && (bus.count != r_prev);
    assign w_wrap  = w_up ? 2'b01 : (w_down ? 2'b10 : 2'b00);

    assign w_level    = r_wr_cnt - r_rd_cnt;
    assign w_nonempty = (w_level != '0);
    assign w_full     = (w_level == LW'(DEPTH));
    assign w_wr_ptr   = r_wr_cnt[AW-1:0];
    assign w_rd_ptr   = r_rd_cnt[AW-1:0];

    assign w_push  = w_sample && (w_up || w_down || w_match);
    assign w_pop   = w_nonempty && bus.evt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev   <= '0;
            r_cmp    <= '0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (bus.count_vld) begin
                r_prev <= bus.count;
            end
            if (bus.cmp_load) begin
                r_cmp <= bus.cmp_val;
            end
            if (w_wr_en) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (w_pop) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_wrap[w_wr_ptr]  <= w_wrap;
            r_mem_match[w_wr_ptr] <= w_match;
            r_mem_count[w_wr_ptr] <= bus.count;
        end
    end

    assign bus.evt_valid  = w_nonempty;
    assign bus.evt_wrap   = w_nonempty ? r_mem_wrap[w_rd_ptr]  : 2'b00;
    assign bus.evt_match  = w_nonempty ? r_mem_match[w_rd_ptr] : 1'b0;
    assign bus.evt_count  = w_nonempty ? r_mem_count[w_rd_ptr] : '0;
    assign bus.fifo_level = w_level;
    assign bus.ovf        = r_ovf;

`ifdef COUNT_EVT_TIMESTAMP_EN
    logic [15:0] r_ts;
    logic [15:0] r_mem_ts [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_ts[w_wr_ptr] <= r_ts;
        end
    end

    assign bus.evt_ts = w_nonempty ? r_mem_ts[w_rd_ptr] : 16'd0;
`endif
endmodule
